// File: rtl/light_pkg.sv
// Shared phase encoding and lamp constants for the two-road crossing.
package light_pkg;

   typedef enum logic [2:0] {
      AR_NS = 3'd0,
      NS_G  = 3'd1,
      NS_Y  = 3'd2,
      AR_EW = 3'd3,
      EW_G  = 3'd4,
      EW_Y  = 3'd5
   } phase_t;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: cleared on phase change, saturates at all-ones.
module phase_timer #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             res,
   input  logic             clr,
   output logic [CNT_W-1:0] t
);

   localparam logic [CNT_W-1:0] T_SAT = '1;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         t <= '0;
      end else if (clr) begin
         t <= '0;
      end else if (t != T_SAT) begin
         t <= t + 1'b1;
      end
   end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road crossing scheduler: alternating greens with min/max length,
// fixed yellow and all-red gap, Moore lamp decode from the phase register.
module traffic_light_ctrl
   import light_pkg::*;
#(
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 16,
   parameter int YELLOW_T  = 2,
   parameter int ALLRED_T  = 1,
   parameter int CNT_W     = 5
) (
   input  logic       clk,
   input  logic       res,
   input  logic       car_ns,
   input  logic       car_ew,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic [2:0] phase,
   output logic       grant_pulse
);

   localparam logic [CNT_W-1:0] GMIN_T = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] GMAX_T = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] YEL_T  = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] AR_T   = CNT_W'(ALLRED_T - 1);

   phase_t           phase_q;
   phase_t           phase_d;
   logic             gp_q;
   logic             gp_d;
   logic             clr;
   logic [CNT_W-1:0] t;

   phase_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk(clk),
      .res(res),
      .clr(clr),
      .t  (t)
   );

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         phase_q <= AR_NS;
         gp_q    <= 1'b0;
      end else begin
         phase_q <= phase_d;
         gp_q    <= gp_d;
      end
   end

   // A green yields only when the other road waits and either its own
   // road is empty or the max-green cap has been reached.
   always_comb begin
      phase_d = phase_q;
      case (phase_q)
         AR_NS: if (t == AR_T) phase_d = NS_G;
         NS_G: begin
            if (t >= GMIN_T && car_ew && (!car_ns || t >= GMAX_T))
               phase_d = NS_Y;
         end
         NS_Y:  if (t == YEL_T) phase_d = AR_EW;
         AR_EW: if (t == AR_T) phase_d = EW_G;
         EW_G: begin
            if (t >= GMIN_T && car_ns && (!car_ew || t >= GMAX_T))
               phase_d = EW_Y;
         end
         EW_Y:  if (t == YEL_T) phase_d = AR_NS;
         default: phase_d = AR_NS;
      endcase
   end

   assign clr  = (phase_d != phase_q);
   assign gp_d = clr && (phase_d == NS_G || phase_d == EW_G);

   always_comb begin
      ns_light = RED;
      ew_light = RED;
      case (phase_q)
         NS_G:    ns_light = GRN;
         NS_Y:    ns_light = YEL;
         EW_G:    ew_light = GRN;
         EW_Y:    ew_light = YEL;
         default: ;
      endcase
   end

   assign phase       = phase_q;
   assign grant_pulse = gp_q;

endmodule
